// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel servo PWM driver.
// Angle commands are converted to pulse widths (angle*SCALE+OFFSET, saturated
// so every frame keeps a low gap) and held in a pending buffer. The buffer is
// applied to the active widths only at a frame boundary, so a pulse never
// changes mid-frame. All channels share one prescaler and one frame counter.
// Optional build macro SERVO_SLEW_EN: pending widths become targets, and the
// active widths move toward them by at most SLEW_STEP ticks per frame.
module servo_pwm_array #(
  parameter int N_CH      = 5,
  parameter int ANGLE_W   = 8,
  parameter int PULSE_W   = 12,
  parameter int SCALE     = 11,
  parameter int OFFSET    = 500,
  parameter int PERIOD    = 2000,
  parameter int TICK_DIV  = 50,
  parameter int SLEW_STEP = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [N_CH*ANGLE_W-1:0]   cmd_angles,
  output logic [N_CH-1:0]           pwm_out,
  output logic                      frame_start,
  output logic [N_CH*PULSE_W-1:0]   width_active
);

  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_CODE = (1 << PULSE_W) - 1;
  localparam int SAT      = (PERIOD - 1 < MAX_CODE) ? PERIOD - 1 : MAX_CODE;
  localparam int FULL_W   = ANGLE_W + 34;

`ifdef SERVO_SLEW_EN
  localparam int STEP_LIM = SLEW_STEP;
`else
  // Without slewing the step limit spans the whole width range, so a target
  // always lands completely in a single frame.
  localparam int STEP_LIM = (SLEW_STEP > SAT) ? SLEW_STEP : SAT;
`endif

  logic [PS_W-1:0]    presc;
  logic [PULSE_W-1:0] frame_cnt;
  logic               armed;
  logic               pend_valid;
  logic [PULSE_W-1:0] pend_w [N_CH];
  logic [PULSE_W-1:0] act_w  [N_CH];
  logic [PULSE_W-1:0] next_w [N_CH];
  logic               all_done;
  logic               tick;
  logic               boundary;
  logic               accept;

  // Full-precision conversion, clamped to the largest width that still leaves
  // at least one low tick per frame.
  function automatic logic [PULSE_W-1:0] angle_to_width(input logic [ANGLE_W-1:0] angle);
    logic [FULL_W-1:0] full;
    full = FULL_W'(angle) * FULL_W'(SCALE) + FULL_W'(OFFSET);
    if (full > FULL_W'(SAT))
      angle_to_width = PULSE_W'(SAT);
    else
      angle_to_width = full[PULSE_W-1:0];
  endfunction

  // Move cur toward tgt by at most STEP_LIM, never overshooting.
  function automatic logic [PULSE_W-1:0] step_toward(input logic [PULSE_W-1:0] cur,
                                                      input logic [PULSE_W-1:0] tgt);
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (t > c + STEP_LIM)
      step_toward = PULSE_W'(c + STEP_LIM);
    else if (t < c - STEP_LIM)
      step_toward = PULSE_W'(c - STEP_LIM);
    else
      step_toward = tgt;
  endfunction

  assign tick     = enable && (presc == PS_W'(TICK_DIV - 1));
  // The first tick after enable (or reset) opens a fresh frame at count 0.
  assign boundary = tick && (!armed || frame_cnt == PULSE_W'(PERIOD - 1));
  assign accept   = cmd_valid && cmd_ready;

  // Widths the active set would take at the next boundary, and whether that
  // step reaches every target.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      next_w[i] = step_toward(act_w[i], pend_w[i]);
      if (next_w[i] != pend_w[i])
        all_done = 1'b0;
    end
  end

  // Tick prescaler and frame counter; both parked at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      frame_cnt <= '0;
      armed     <= 1'b0;
    end else if (!enable) begin
      presc     <= '0;
      frame_cnt <= '0;
      armed     <= 1'b0;
    end else if (tick) begin
      presc <= '0;
      armed <= 1'b1;
      if (armed) begin
        if (frame_cnt == PULSE_W'(PERIOD - 1))
          frame_cnt <= '0;
        else
          frame_cnt <= frame_cnt + 1'b1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // One-clock frame marker, registered from the boundary condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_start <= 1'b0;
    else
      frame_start <= boundary;
  end

  // Command handshake and double buffer: accept into pending, apply at boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      cmd_ready  <= 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        pend_w[i] <= '0;
        act_w[i]  <= PULSE_W'(OFFSET);
      end
    end else if (boundary && pend_valid) begin
      for (int i = 0; i < N_CH; i++)
        act_w[i] <= next_w[i];
      pend_valid <= !all_done;
      cmd_ready  <= all_done;
    end else if (accept) begin
      for (int i = 0; i < N_CH; i++)
        pend_w[i] <= angle_to_width(cmd_angles[i*ANGLE_W +: ANGLE_W]);
      pend_valid <= 1'b1;
      cmd_ready  <= 1'b0;
    end
  end

  // Pin compare, one clock behind the counter; held low until a frame runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        pwm_out[i] <= enable && armed && (frame_cnt < act_w[i]);
    end
  end

  // Flatten the active widths onto the status bus.
  always_comb begin
    width_active = '0;
    for (int i = 0; i < N_CH; i++)
      width_active[i*PULSE_W +: PULSE_W] = act_w[i];
  end

endmodule
